quick_rs232_host_tx: RTL and testbench

Host-side (PC/DTE end) RS-232 transmitter with RTS/CTS hardware flow control, serving as the counterpart of the device-side receiver in quick_rs232. It accepts bytes over a valid/ready handshake, raises rts, and waits for the device's cts when flow control is enabled. It then serialises a start bit, data bits LSB first, an optional parity bit and the stop bit(s) onto tx. It is used as a synthesizable bench driver and as the host end in loopback systems.

---
 rtl/quick_rs232_host_tx.sv | 168 ++++++++++++++++
 tb/tb_quick_rs232_host_tx.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/quick_rs232_host_tx.sv
// rtl/quick_rs232_host_tx.sv - host-side RS-232 transmitter with RTS/CTS flow control
module quick_rs232_host_tx #(
  parameter int CLK_FREQ     = 50000000,
  parameter int BAUD_RATE    = 115200,
  parameter int BYTE_LEN     = 8,
  parameter int PARITY       = 1,
  parameter int STOP_BITS    = 0,
  parameter int FLOW_CONTROL = 1,
  parameter int CTS_TIMEOUT  = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic       tx,
  output logic       rts,
  input  logic       cts,
  output logic       busy,
  output logic       frame_done,
  output logic       cts_timeout
);

  localparam int BIT_CLKS = CLK_FREQ / BAUD_RATE;
  localparam int BW       = $clog2(BIT_CLKS + 1);

  localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_CLKS - 1);
  localparam logic [BW-1:0] BIT_PRE   = BW'(BIT_CLKS - 2);
  localparam logic [2:0]    DATA_LAST = 3'(BYTE_LEN - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS);
  localparam logic [7:0]    MASK      = 8'((1 << BYTE_LEN) - 1);
  localparam logic [31:0]   WAIT_LAST = 32'(CTS_TIMEOUT - 1);
  localparam logic          ODD       = (PARITY == 2);

  typedef enum logic [2:0] {IDLE, REQ, START, DATA, PAR, STOP} state_t;

  state_t        state;
  logic [BW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [31:0]   wait_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          cts_q1;
  logic          cts_s;
  logic          wrap;

  assign wrap = (bit_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cts_q1 <= 1'b0;
      cts_s  <= 1'b0;
    end else begin
      cts_q1 <= cts;
      cts_s  <= cts_q1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      tx          <= 1'b1;
      rts         <= 1'b0;
      data_ready  <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      cts_timeout <= 1'b0;
      bit_cnt     <= '0;
      bit_idx     <= '0;
      wait_cnt    <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      cts_timeout <= 1'b0;
      if (state inside {START, DATA, PAR, STOP})
        bit_cnt <= wrap ? '0 : bit_cnt + 1'b1;

      case (state)
        IDLE: begin
          tx         <= 1'b1;
          rts        <= 1'b0;
          busy       <= 1'b0;
          data_ready <= 1'b1;
          if (data_valid && data_ready) begin
            shreg      <= data_in & MASK;
            par_bit    <= (^(data_in & MASK)) ^ ODD;
            wait_cnt   <= '0;
            data_ready <= 1'b0;
            rts        <= 1'b1;
            busy       <= 1'b1;
            state      <= REQ;
          end
        end

        REQ: begin
          wait_cnt <= wait_cnt + 1'b1;
          // Without flow control REQ still lasts two clocks so tx falls at T+2
          if ((FLOW_CONTROL == 0) ? (wait_cnt != 32'd0) : cts_s) begin
            state   <= START;
            tx      <= 1'b0;
            bit_cnt <= '0;
          end else if (FLOW_CONTROL != 0 && CTS_TIMEOUT != 0 && wait_cnt == WAIT_LAST) begin
            cts_timeout <= 1'b1;
            rts         <= 1'b0;
            busy        <= 1'b0;
            data_ready  <= 1'b1;
            state       <= IDLE;
          end
        end

        START: begin
          if (wrap) begin
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            bit_idx <= '0;
            state   <= DATA;
          end
        end

        DATA: begin
          if (wrap) begin
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                tx    <= par_bit;
                state <= PAR;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

        PAR: begin
          if (wrap) begin
            tx      <= 1'b1;
            bit_idx <= '0;
            state   <= STOP;
          end
        end

        STOP: begin
          if (bit_idx == STOP_LAST && bit_cnt == BIT_PRE)
            frame_done <= 1'b1;
          if (wrap) begin
            if (bit_idx == STOP_LAST) begin
              rts        <= 1'b0;
              busy       <= 1'b0;
              data_ready <= 1'b1;
              state      <= IDLE;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_quick_rs232_host_tx.sv
// tb/tb_quick_rs232_host_tx.sv - directed bench for quick_rs232_host_tx
module tb_quick_rs232_host_tx;

  localparam int BIT = 434;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = 8'h00;
  logic [3:0] dv = 4'h0;
  logic [3:0] ctss = 4'h0;
  logic [3:0] dr, txs, rtss, busys, fds, ctos;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // 0: 8E1 no flow, 1: 7O2 no flow, 2: 8E1 flow, 3: 8E1 flow with timeout
  quick_rs232_host_tx #(.BYTE_LEN(8), .PARITY(1), .STOP_BITS(0), .FLOW_CONTROL(0), .CTS_TIMEOUT(0)) dut_a (
    .clk(clk), .rst(rst), .data_in(din), .data_valid(dv[0]), .data_ready(dr[0]), .tx(txs[0]),
    .rts(rtss[0]), .cts(ctss[0]), .busy(busys[0]), .frame_done(fds[0]), .cts_timeout(ctos[0]));
  quick_rs232_host_tx #(.BYTE_LEN(7), .PARITY(2), .STOP_BITS(1), .FLOW_CONTROL(0), .CTS_TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst), .data_in(din), .data_valid(dv[1]), .data_ready(dr[1]), .tx(txs[1]),
    .rts(rtss[1]), .cts(ctss[1]), .busy(busys[1]), .frame_done(fds[1]), .cts_timeout(ctos[1]));
  quick_rs232_host_tx #(.BYTE_LEN(8), .PARITY(1), .STOP_BITS(0), .FLOW_CONTROL(1), .CTS_TIMEOUT(0)) dut_c (
    .clk(clk), .rst(rst), .data_in(din), .data_valid(dv[2]), .data_ready(dr[2]), .tx(txs[2]),
    .rts(rtss[2]), .cts(ctss[2]), .busy(busys[2]), .frame_done(fds[2]), .cts_timeout(ctos[2]));
  quick_rs232_host_tx #(.BYTE_LEN(8), .PARITY(1), .STOP_BITS(0), .FLOW_CONTROL(1), .CTS_TIMEOUT(1000)) dut_d (
    .clk(clk), .rst(rst), .data_in(din), .data_valid(dv[3]), .data_ready(dr[3]), .tx(txs[3]),
    .rts(rtss[3]), .cts(ctss[3]), .busy(busys[3]), .frame_done(fds[3]), .cts_timeout(ctos[3]));

  typedef struct {
    string      name;
    int         dut;
    logic [7:0] data;
    logic [11:0] frame;
    int         nbits;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input int d, input logic [7:0] data, input string name);
    @(negedge clk);
    din   = data;
    dv[d] = 1'b1;
    @(negedge clk);
    dv[d] = 1'b0;
    check({name, "_accept_rts"}, int'(rtss[d]), 1);
  endtask

  task automatic wait_fall(input int d, input int limit, output int lat);
    lat = 0;
    while (txs[d] !== 1'b0 && lat < limit) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Starts on the first sampled clock of the start bit; ends one clock after the frame.
  task automatic check_frame(input int d, input logic [11:0] frame, input int nbits, input string name);
    int fd_err = 0;
    for (int i = 0; i < nbits; i++) begin
      int errs = 0;
      for (int k = 0; k < BIT; k++) begin
        logic fd_exp;
        fd_exp = (i == nbits - 1) && (k == BIT - 1);
        if (txs[d] !== frame[i]) errs++;
        if (fds[d] !== fd_exp) fd_err++;
        @(negedge clk);
      end
      check($sformatf("%s_bit%0d_bad_clocks", name, i), errs, 0);
    end
    check({name, "_frame_done_bad_clocks"}, fd_err, 0);
    check({name, "_tx_idle"}, int'(txs[d]), 1);
    check({name, "_busy_after"}, int'(busys[d]), 0);
    check({name, "_ready_after"}, int'(dr[d]), 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, cnt, errs;

    vecs[0] = '{"a5_8e1", 0, 8'hA5, 12'h54A, 11};
    vecs[1] = '{"ff_8e1", 0, 8'hFF, 12'h5FE, 11};
    vecs[2] = '{"00_8e1", 0, 8'h00, 12'h400, 11};
    vecs[3] = '{"41_7o2", 1, 8'h41, 12'h782, 11};
    vecs[4] = '{"ff_7o2", 1, 8'hFF, 12'h6FE, 11};

    // Reset with data_valid asserted
    rst = 1'b0;
    dv  = 4'hF;
    repeat (5) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      check($sformatf("rst_tx%0d", d), int'(txs[d]), 1);
      check($sformatf("rst_rts%0d", d), int'(rtss[d]), 0);
      check($sformatf("rst_ready%0d", d), int'(dr[d]), 0);
    end
    rst = 1'b1;
    dv  = 4'h0;
    @(negedge clk);
    for (int d = 0; d < 4; d++)
      check($sformatf("rel_ready%0d", d), int'(dr[d]), 1);

    foreach (vecs[v]) begin
      send(vecs[v].dut, vecs[v].data, vecs[v].name);
      wait_fall(vecs[v].dut, 5000, lat);
      check({vecs[v].name, "_latency"}, lat, 2);
      check_frame(vecs[v].dut, vecs[v].frame, vecs[v].nbits, vecs[v].name);
    end

    // Flow control: hold in REQ until cts, then a mid-frame cts drop is ignored
    ctss[2] = 1'b0;
    send(2, 8'h3C, "fc");
    errs = 0;
    repeat (300) begin
      if (txs[2] !== 1'b1) errs++;
      @(negedge clk);
    end
    check("fc_hold_tx_bad_clocks", errs, 0);
    check("fc_hold_rts", int'(rtss[2]), 1);
    check("fc_hold_busy", int'(busys[2]), 1);
    ctss[2] = 1'b1;
    wait_fall(2, 20, lat);
    check("fc_cts_latency", lat, 3);
    fork
      begin
        repeat (2000) @(negedge clk);
        ctss[2] = 1'b0;
      end
    join_none
    check_frame(2, 12'h478, 11, "fc_3c");
    check("fc_rts_after", int'(rtss[2]), 0);

    // CTS timeout
    ctss[3] = 1'b0;
    send(3, 8'h55, "to");
    cnt  = 0;
    errs = 0;
    while (ctos[3] !== 1'b1 && cnt < 2000) begin
      if (txs[3] !== 1'b1) errs++;
      @(negedge clk);
      cnt++;
    end
    check("to_pulse_delay", cnt, 1000);
    check("to_tx_bad_clocks", errs, 0);
    check("to_rts", int'(rtss[3]), 0);
    check("to_ready", int'(dr[3]), 1);
    @(negedge clk);
    check("to_pulse_width", int'(ctos[3]), 0);
    check("to_ready_next", int'(dr[3]), 1);

    // Back-to-back with data_valid held high, then reset mid-frame
    @(negedge clk);
    din   = 8'h01;
    dv[0] = 1'b1;
    @(negedge clk);
    check("b2b_accept1_rts", int'(rtss[0]), 1);
    din = 8'h02;
    wait_fall(0, 20, lat);
    check("b2b_latency1", lat, 2);
    check_frame(0, 12'h602, 11, "b2b_01");
    check("b2b_gap_rts_low", int'(rtss[0]), 0);
    @(negedge clk);
    check("b2b_gap_rts_high", int'(rtss[0]), 1);
    check("b2b_ready_low", int'(dr[0]), 0);
    dv[0] = 1'b0;
    wait_fall(0, 20, lat);
    check("b2b_latency2", lat, 2);
    repeat (3 * BIT) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_tx", int'(txs[0]), 1);
    check("abort_rts", int'(rtss[0]), 0);
    check("abort_busy", int'(busys[0]), 0);
    rst = 1'b1;
    cnt = 0;
    repeat (500) begin
      if (fds[0] !== 1'b0 || txs[0] !== 1'b1) cnt++;
      @(negedge clk);
    end
    check("abort_quiet_bad_clocks", cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
